// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in and
// produces their sum LSB first, one bit per clock. Define SERIAL_ADD_COUT_EN to expose the final carry on cout.

// One-bit full adder cell; the only sum/carry logic in the datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             busy
`ifdef SERIAL_ADD_COUT_EN
  ,
  output logic             cout
`endif
);

  // Counter must reach WIDTH-1 without wrapping; wide enough to hold WIDTH itself.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, a_sh_nxt;
  logic [WIDTH-1:0]   b_sh, b_sh_nxt;
  logic [WIDTH-1:0]   sum_nxt;
  logic               carry, carry_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               fa_s, fa_co;

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_sh_nxt  = b_sh;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    sum_nxt   = sum;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_sh_nxt  = a;
          b_sh_nxt  = b;
          carry_nxt = cin;
          cnt_nxt   = '0;
          sum_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        sum_nxt      = sum >> 1;
        sum_nxt[MSB] = fa_s;
        carry_nxt    = fa_co;
        a_sh_nxt     = a_sh >> 1;
        b_sh_nxt     = b_sh >> 1;
        cnt_nxt      = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and status flops; status bits track the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      a_sh      <= a_sh_nxt;
      b_sh      <= b_sh_nxt;
      carry     <= carry_nxt;
      cnt       <= cnt_nxt;
      sum       <= sum_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == RUN);
    end
  end

`ifdef SERIAL_ADD_COUT_EN
  assign cout = carry;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed vectors against a transaction-level model
// checked every cycle, plus literal expectations for key cases (WIDTH=32 and WIDTH=1).
module tb_serial_add_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready, cin;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] sum;
  logic         in_valid1, out_ready1, cin1;
  logic [0:0]   a1, b1;
  logic         in_ready1, out_valid1, busy1;
  logic [0:0]   sum1;
`ifdef SERIAL_ADD_COUT_EN
  logic         cout, cout1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
`ifdef SERIAL_ADD_COUT_EN
    , .cout(cout)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .busy(busy1)
`ifdef SERIAL_ADD_COUT_EN
    , .cout(cout1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle -> running for W edges -> done until out_ready.
  logic         m_idle, m_run, m_done;
  int           m_cyc;
  logic [W-1:0] m_sum;
  logic         m_cout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1'b1; m_run = 1'b0; m_done = 1'b0; m_cyc = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        {m_cout, m_sum} = 33'(a) + 33'(b) + 33'(cin);
        m_idle = 1'b0; m_run = 1'b1; m_cyc = 0;
      end
    end else if (m_run) begin
      m_cyc++;
      if (m_cyc == W) begin m_run = 1'b0; m_done = 1'b1; end
    end else if (m_done && out_ready) begin
      m_done = 1'b0; m_idle = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(m_idle));
    chk("busy", 64'(busy), 64'(m_run));
    chk("out_valid", 64'(out_valid), 64'(m_done));
    if (m_done) begin
      chk("sum_model", 64'(sum), 64'(m_sum));
`ifdef SERIAL_ADD_COUT_EN
      chk("cout_model", 64'(cout), 64'(m_cout));
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Accept one operation, measure latency, check the literal result, then drain it.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] exp_sum, input logic exp_cout);
    int cnt;
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~va; b = vb ^ 32'h5A5A_A5A5; cin = ~vc;
    chk({name, "_model_pin"}, 64'(m_sum), 64'(exp_sum));
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk); #1; cnt++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, 64'(cnt), 64'(W));
    chk({name, "_sum"}, 64'(sum), 64'(exp_sum));
`ifdef SERIAL_ADD_COUT_EN
    chk({name, "_cout"}, 64'(cout), 64'(exp_cout));
`else
    chk({name, "_model_cout_pin"}, 64'(m_cout), 64'(exp_cout));
`endif
    #1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    int cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_op("basic", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0);
    run_op("allones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    run_op("msb_carry", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    run_op("small", 32'd3, 32'd4, 1'b1, 32'd8, 1'b0);
    run_op("mixed", 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 32'hDEAD_BEF1, 1'b0);

    // Result held under back-pressure while new operands are offered
    a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    chk("bp_valid", 64'(out_valid), 64'd1);
    held = sum;
    chk("bp_sum", 64'(held), 64'h30);
    a = 32'h0000_1000; b = 32'h0000_2000; cin = 1'b1; in_valid = 1'b1;
    repeat (10) begin
      tick();
      chk("bp_hold_sum", 64'(sum), 64'(held));
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_busy", 64'(busy), 64'd1);
    cnt = 0;
    while (cnt < 100 && !out_valid) begin tick(); cnt++; end
    chk("bp_new_sum", 64'(sum), 64'h3001);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset mid-run discards the operation
    a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    tick();
    rst = 1'b0;
    run_op("after_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0);

    // WIDTH=1 instance
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    chk("w1_busy", 64'(busy1), 64'd1);
    chk("w1_not_yet", 64'(out_valid1), 64'd0);
    tick();
    chk("w1_out_valid", 64'(out_valid1), 64'd1);
    chk("w1_sum", 64'(sum1), 64'd1);
`ifdef SERIAL_ADD_COUT_EN
    chk("w1_cout", 64'(cout1), 64'd1);
`endif
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("w1_idle", 64'(in_ready1), 64'd1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents operands.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  operand A, sampled on input handshake.
REQ-007 b  input  WIDTH  operand B, sampled on input handshake.
REQ-008 cin  input  1  initial carry-in, sampled on input handshake.
REQ-009 out_valid  output  1  sum result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-012 busy  output  1  high while in RUN state.

Function
REQ-013 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, using a single instance of the team's one-bit fulladder cell as the only sum/carry logic.
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-016 IDLE: on an edge with in_valid=1, latch a and b into shift registers, carry register <= cin, bit counter <= 0, sum register <= 0, go to RUN; otherwise stay.
REQ-017 RUN: each edge, feed shift-register LSBs and carry register to the fulladder, shift its s into the sum register from the MSB side, carry register <= co, shift operands right, increment counter.
REQ-018 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH clocks after the accepting edge.
REQ-020 DONE: sum held stable; on an edge with out_ready=1, go to IDLE; out_ready=0 holds DONE indefinitely.
REQ-021 in_valid SHALL be ignored outside IDLE; a and b may change freely after the accepting edge.
REQ-022 No same-cycle output-accept and input-accept; minimum issue interval WIDTH+2 clocks.
REQ-023 WIDTH=1: RUN lasts one edge; the counter SHALL be at least 1 bit wide and SHALL not overflow for WIDTH=64.
REQ-024 sum SHALL show the partially shifted register during RUN; it is valid only when out_valid=1.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, regardless of state, including mid-RUN.
REQ-026 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, carry/counter/shift registers=0, cout=0 when present.
REQ-027 An operation interrupted by reset SHALL be discarded with no result produced; first accept possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro SERIAL_ADD_COUT_EN: when defined, add output port cout (1 bit), equal to the final carry register, valid with out_valid and held stable in DONE.
REQ-029 Without SERIAL_ADD_COUT_EN, the cout port SHALL not exist and the final carry SHALL be discarded; all other behaviour SHALL be identical.

Verification (WIDTH=32 unless stated)
REQ-030 a=0x12345678, b=0x9ABCDEF0, cin=0 -> sum=0xACF13568, cout=0, out_valid exactly 32 clocks after accept.
REQ-031 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (macro on); no cout port (macro off).
REQ-032 Result ready, out_ready held 0 for 10 clocks while in_valid=1 with new operands -> out_valid stays 1, sum stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE next edge, then new operands accepted.
REQ-033 rst pulsed after bit 10 of RUN -> outputs immediately at reset values; after release, a=3, b=4, cin=0 -> sum=7 after 32 clocks.
REQ-034 WIDTH=1 instance, a=1, b=1, cin=1 -> sum=1, cout=1, out_valid 1 clock after accept.
